uart_tx_scheduler: RTL and testbench

//  Shares one UART transmitter (Uart_TopModule TX path) among NUM_REQ byte producers.

---
 rtl/uart_tx_scheduler_pkg.sv | 24 ++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 32 +++
 rtl/uart_tx_scheduler.sv | 127 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding,
// bit-time formula and counter sizing helper.
package uart_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int TIMEOUT_MULT = 12;

    function automatic int bit_cycles(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Width that holds 0..max(a,b) without wrapping.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: lowest-distance requester from ptr wins,
// result given as one-hot grant, binary index and an any-request flag.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = IW'((int'(ptr) + k) % N);
            if (!any && req[pos]) begin
                any        = 1'b1;
                idx        = pos;
                grant[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte producers: round-robin accept,
// hold the byte for the whole frame, enforce an idle gap and abort hung frames.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int clk_rate    = 1000000,
    parameter int baud_rate   = 9600,
    parameter int BIT_CYCLES  = bit_cycles(clk_rate, baud_rate),
    parameter int GAP_CYCLES  = BIT_CYCLES,
    parameter int TIMEOUT_CYC = TIMEOUT_MULT * BIT_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = cnt_width(TIMEOUT_CYC, GAP_CYCLES);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    wd_cnt;
    logic [CW-1:0]    gap_cnt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   rr_ptr_nxt;
    logic [NUM_REQ-1:0] win_grant;
    logic [IDW-1:0]   win_idx;
    logic             win_any;
    logic [7:0]       win_byte;
    logic             accept;
    logic             abort;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_grant[i]) begin
                win_byte = req_data[8*i +: 8];
            end
        end
    end

    assign rr_ptr_nxt = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    // Ready is only offered while idle and never while reset is held.
    assign req_ready = (state == ST_IDLE && rst) ? win_grant : '0;
    assign tx_start  = (state == ST_BUSY);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_any) begin
                    accept    = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A completing frame takes priority over the watchdog.
                if (tx_done) begin
                    state_nxt = ST_GAP;
                end else if (wd_cnt == CW'(TIMEOUT_CYC - 1)) begin
                    abort     = 1'b1;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == CW'(GAP_CYCLES - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            wd_cnt      <= '0;
            gap_cnt     <= '0;
            rr_ptr      <= '0;
            tx_data     <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            timeout_err <= abort;
            if (accept) begin
                tx_data  <= win_byte;
                grant_id <= win_idx;
                rr_ptr   <= rr_ptr_nxt;
            end
            if (state == ST_BUSY && state_nxt == ST_BUSY) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
            if (state == ST_GAP && state_nxt == ST_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: requester queues and a transmitter stand-in drive
// the DUT while a cycle-level model of the scheduling rules predicts every output.
module tb_uart_tx_scheduler;

    localparam int N   = 4;
    localparam int GAP = 104;
    localparam int TMO = 1248;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid;
    logic [N*8-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             tx_done;
    logic [1:0]       grant_id;
    logic             busy;
    logic             timeout_err;

    uart_tx_scheduler #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Requester byte queues and the log of bytes the model saw accepted.
    logic [7:0] req_q [N][$];
    logic [7:0] sent_log [$];

    // Model: mode 0 = idle, 1 = frame in flight, 2 = inter-frame gap.
    int         m_mode, m_cnt, m_ptr, m_gid, m_done_at;
    logic [7:0] m_data;
    logic       m_terr;
    int         next_done_at = 20;
    logic       spur = 1'b0;

    int n_start, n_gap, n_terr, n_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find_winner();
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (req_q[i].size() > 0) return i;
        end
        return -1;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (req_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_ptr = 0; m_gid = 0; m_data = 8'h00; m_terr = 1'b0;
        m_done_at = -1;
    endtask

    task automatic clr_meas();
        n_start = 0; n_gap = 0; n_terr = 0; n_ready = 0;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]      = (req_q[i].size() > 0);
            req_data[8*i +: 8] = (req_q[i].size() > 0) ? req_q[i][0] : 8'h00;
        end
        tx_done = rst && (spur || (m_mode == 1 && m_cnt == m_done_at));
    endtask

    // One clock: drive at the falling edge, compare 1 time unit later,
    // then advance the model across the coming rising edge.
    task automatic step();
        int w;
        logic [N-1:0] er;
        drive_inputs();
        #1;
        w  = find_winner();
        er = '0;
        if (rst && m_mode == 0 && w >= 0) er[w] = 1'b1;
        check("req_ready",   32'(req_ready),   32'(er));
        check("tx_start",    32'(tx_start),    32'(m_mode == 1));
        check("busy",        32'(busy),        32'(m_mode != 0));
        check("tx_data",     32'(tx_data),     32'(m_data));
        check("grant_id",    32'(grant_id),    32'(m_gid));
        check("timeout_err", 32'(timeout_err), 32'(m_terr));
        if (tx_start) n_start++;
        if (busy && !tx_start) n_gap++;
        if (timeout_err) n_terr++;
        if (req_ready != '0) n_ready++;
        if (!rst) begin
            model_reset();
        end else begin
            m_terr = 1'b0;
            case (m_mode)
                0: if (w >= 0) begin
                    m_data    = req_q[w].pop_front();
                    sent_log.push_back(m_data);
                    m_gid     = w;
                    m_ptr     = (w + 1) % N;
                    m_mode    = 1;
                    m_cnt     = 0;
                    m_done_at = next_done_at;
                end
                1: if (tx_done) begin
                    m_mode = 2; m_cnt = 0;
                end else if (m_cnt == TMO - 1) begin
                    m_mode = 2; m_cnt = 0; m_terr = 1'b1;
                end else begin
                    m_cnt++;
                end
                default: if (m_cnt == GAP - 1) begin
                    m_mode = 0; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            endcase
        end
        spur = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_until_quiet(input int limit);
        int k = 0;
        while ((m_mode != 0 || pending()) && k < limit) begin
            step();
            k++;
        end
        check("quiet_bound", 32'(k < limit), 32'd1);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int sz;
        int k;
        model_reset();
        clr_meas();
        drive_inputs();
        #2 rst = 1'b0;
        req_q[0].push_back(8'h77);
        @(negedge clk);
        step();
        check("rst_ready",   32'(req_ready),   32'd0);
        check("rst_start",   32'(tx_start),    32'd0);
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_gid",     32'(grant_id),    32'd0);
        check("rst_data",    32'(tx_data),     32'd0);
        check("rst_terr",    32'(timeout_err), 32'd0);
        req_q[0].delete();
        step();
        rst = 1'b1;
        step();

        // Single byte, transmitter finishes 1040 cycles into the frame.
        next_done_at = 1039;
        clr_meas();
        req_q[0].push_back(8'hA5);
        step();
        check("t1_start", 32'(tx_start), 32'd1);
        check("t1_data",  32'(tx_data),  32'hA5);
        check("t1_gid",   32'(grant_id), 32'd0);
        run_until_quiet(3000);
        check("t1_frame_len", 32'(n_start), 32'd1040);
        check("t1_gap_len",   32'(n_gap),   32'd104);
        check("t1_ready_n",   32'(n_ready), 32'd1);
        check("t1_log",       32'(sent_log[0]), 32'hA5);

        rst = 1'b0;
        model_reset();
        step();
        step();
        rst = 1'b1;

        // All four requesters, pointer starting at 0.
        next_done_at = 20;
        sent_log.delete();
        req_q[0].push_back(8'h11);
        req_q[1].push_back(8'h22);
        req_q[2].push_back(8'h33);
        req_q[3].push_back(8'h44);
        run_until_quiet(3000);
        req_q[1].push_back(8'h22);
        req_q[3].push_back(8'h44);
        run_until_quiet(3000);
        check("t2_n",  32'(sent_log.size()), 32'd6);
        check("t2_o0", 32'(sent_log[0]), 32'h11);
        check("t2_o1", 32'(sent_log[1]), 32'h22);
        check("t2_o2", 32'(sent_log[2]), 32'h33);
        check("t2_o3", 32'(sent_log[3]), 32'h44);
        check("t2_o4", 32'(sent_log[4]), 32'h22);
        check("t2_o5", 32'(sent_log[5]), 32'h44);

        // Hung transmitter: watchdog aborts after the full budget.
        next_done_at = -1;
        clr_meas();
        sz = sent_log.size();
        req_q[1].push_back(8'h3C);
        run_until_quiet(4000);
        check("t3_frame_len", 32'(n_start), 32'd1248);
        check("t3_terr_n",    32'(n_terr),  32'd1);
        check("t3_gap_len",   32'(n_gap),   32'd104);
        check("t3_ready_n",   32'(n_ready), 32'd1);
        check("t3_no_resend", 32'(sent_log.size()), 32'(sz + 1));

        // Completion on the very last watchdog cycle wins over the abort.
        next_done_at = 1247;
        clr_meas();
        req_q[2].push_back(8'h5D);
        run_until_quiet(4000);
        check("t4_terr_n",    32'(n_terr),  32'd0);
        check("t4_frame_len", 32'(n_start), 32'd1248);
        check("t4_gap_len",   32'(n_gap),   32'd104);

        // Reset 500 cycles into a frame.
        next_done_at = -1;
        req_q[2].push_back(8'hC3);
        k = 0;
        while (!(m_mode == 1 && m_cnt == 500) && k < 3000) begin
            step();
            k++;
        end
        check("t5_reach", 32'(k < 3000), 32'd1);
        check("t5_gid_pre", 32'(grant_id), 32'd2);
        rst = 1'b0;
        model_reset();
        #1;
        check("t5_async_start", 32'(tx_start), 32'd0);
        check("t5_async_busy",  32'(busy),     32'd0);
        check("t5_async_gid",   32'(grant_id), 32'd0);
        check("t5_async_data",  32'(tx_data),  32'd0);
        @(negedge clk);
        req_q[3].push_back(8'hF3);
        req_q[0].push_back(8'h0F);
        step();
        step();
        step();
        next_done_at = 30;
        rst = 1'b1;
        sz = sent_log.size();
        run_until_quiet(3000);
        check("t5_first", 32'(sent_log[sz]),     32'h0F);
        check("t5_second", 32'(sent_log[sz + 1]), 32'hF3);

        // Spurious completions while idle and during the gap.
        next_done_at = 40;
        clr_meas();
        spur = 1'b1;
        step();
        check("t6_idle_busy", 32'(busy), 32'd0);
        req_q[1].push_back(8'h66);
        k = 0;
        while (m_mode != 2 && k < 2000) begin
            step();
            k++;
        end
        spur = 1'b1;
        step();
        run_until_quiet(3000);
        check("t6_frame_len", 32'(n_start), 32'd41);
        check("t6_gap_len",   32'(n_gap),   32'd104);

        // Randomized traffic.
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                int r = $urandom_range(0, N - 1);
                if (req_q[r].size() < 3) req_q[r].push_back(8'($urandom));
            end
            next_done_at = ($urandom_range(0, 24) == 0) ? -1 : int'($urandom_range(0, 60));
            spur = ($urandom_range(0, 39) == 0);
            step();
        end
        next_done_at = 10;
        run_until_quiet(20000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
